lvds_deserializer: RTL and testbench

Receive-side counterpart of the 7:1 LVDS serializer: accepts the DDR-captured line as bit pairs in the fast bit clock domain and rebuilds each 14-bit frame (two 7-bit words). It then searches for frame alignment using a two-word training pattern and delivers aligned word pairs with a valid strobe once lock is achieved. It sits after the IDDR2 capture stage and before the pixel-clock-domain consumer.

---
 rtl/lvds_pkg.sv | 26 ++
 rtl/lvds_frame_unpack.sv | 27 ++
 rtl/lvds_deserializer.sv | 130 +++++++++++++
 tb/tb_lvds_deserializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// lvds_pkg: shared constants, FSM state type and offset helper for the
// 7:1 LVDS deserializer and its frame unpacker.
package lvds_pkg;

    localparam int WORD_W  = 7;
    localparam int FRAME_W = 14;
    localparam int PAIRS   = 7;

    // Default training pattern and lock threshold.
    localparam logic [WORD_W-1:0] TRAIN_A_DEF    = 7'b1100011;
    localparam logic [WORD_W-1:0] TRAIN_B_DEF    = 7'b0011100;
    localparam int                LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } lvds_state_t;

    // Offset advances one bit per failed frame and wraps across the
    // 14 possible frame alignments.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd13) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/lvds_frame_unpack.sv
// lvds_frame_unpack: combinational split of a 14-bit frame into two
// 7-bit words.
//   f      in  14  frame bits, f[i] = Fi (F0 earliest in time)
//   word_a out  7  first word  (A0..A6)
//   word_b out  7  second word (B0..B6)
module lvds_frame_unpack
    import lvds_pkg::*;
(
    input  logic [FRAME_W-1:0] f,
    output logic [WORD_W-1:0]  word_a,
    output logic [WORD_W-1:0]  word_b
);

    // Pair p holds {F(2p), F(2p+1)}: earlier bit in [1].
    logic [PAIRS-1:0][1:0] p;

    always_comb begin
        p = '0;
        for (int i = 0; i < PAIRS; i++)
            p[i] = {f[2*i], f[2*i+1]};
    end

    // Word A takes the first 3.5 pairs, word B the rest; P3 straddles both.
    assign word_a = {p[3][1], p[2][0], p[2][1], p[1][0], p[1][1], p[0][0], p[0][1]};
    assign word_b = {p[6][0], p[6][1], p[5][0], p[5][1], p[4][0], p[4][1], p[3][0]};

endmodule

// File: rtl/lvds_deserializer.sv
// lvds_deserializer: rebuilds 14-bit frames from DDR-captured bit pairs,
// searches for frame alignment using a two-word training pattern and
// delivers aligned word pairs once locked.
//   clk     in   1  bit-pair clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   din     in   2  captured pair, din[1] earlier bit, din[0] later bit
//   realign in   1  pulse: drop lock and restart the search
//   word_a  out  7  first word of the latest locked frame
//   word_b  out  7  second word of the latest locked frame
//   valid   out  1  one-cycle strobe per frame while locked
//   locked  out  1  alignment achieved
//   offset  out  4  current bit offset, 0..13
module lvds_deserializer
    import lvds_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_A    = TRAIN_A_DEF,
    parameter logic [WORD_W-1:0] TRAIN_B    = TRAIN_B_DEF,
    parameter int                LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        din,
    input  logic              realign,
    output logic [WORD_W-1:0] word_a,
    output logic [WORD_W-1:0] word_b,
    output logic              valid,
    output logic              locked,
    output logic [3:0]        offset
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    logic [2:0]        phase;
    logic [27:0]       hist;
    logic [3:0]        cnt;
    lvds_state_t       state;

    logic [29:0]       win;
    logic [FRAME_W-1:0] slice, frame;
    logic [WORD_W-1:0] ua, ub;
    logic              boundary, match;

    // Newest bit sits at win[0]; offset k slides the frame k bits older.
    assign win   = {hist, din};
    assign slice = 14'(win >> offset);

    // slice[13] is the oldest bit (F0), slice[0] the newest (F13).
    always_comb begin
        frame = '0;
        for (int i = 0; i < FRAME_W; i++)
            frame[i] = slice[FRAME_W-1-i];
    end

    lvds_frame_unpack u_unpack (
        .f      (frame),
        .word_a (ua),
        .word_b (ub)
    );

    assign boundary = (phase == 3'd6);
    assign match    = (ua == TRAIN_A) && (ub == TRAIN_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= '0;
            hist   <= '0;
            cnt    <= '0;
            state  <= HUNT;
            offset <= '0;
            word_a <= '0;
            word_b <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
        end else begin
            phase <= boundary ? 3'd0 : phase + 3'd1;
            hist  <= {hist[25:0], din};
            valid <= 1'b0;

            // realign overrides any frame-boundary decision and output update.
            if (realign) begin
                state  <= HUNT;
                cnt    <= '0;
                locked <= 1'b0;
            end else if (boundary) begin
                case (state)
                    HUNT: begin
                        if (match) begin
                            cnt <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                valid  <= 1'b1;
                                word_a <= ua;
                                word_b <= ub;
                            end else begin
                                state <= CHECK;
                            end
                        end else begin
                            offset <= next_offset(offset);
                        end
                    end
                    CHECK: begin
                        if (match) begin
                            cnt <= cnt + 4'd1;
                            // The frame that completes the count is delivered.
                            if (cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                valid  <= 1'b1;
                                word_a <= ua;
                                word_b <= ub;
                            end
                        end else begin
                            state  <= HUNT;
                            cnt    <= '0;
                            offset <= next_offset(offset);
                        end
                    end
                    LOCKED: begin
                        valid  <= 1'b1;
                        word_a <= ua;
                        word_b <= ub;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lvds_deserializer.sv
// tb_lvds_deserializer: directed bench for lvds_deserializer. A bit queue
// models the serial line (F0 first); each cycle pops two bits into din.
module tb_lvds_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din = '0;
    logic       realign = 1'b0;
    logic [6:0] word_a, word_b;
    logic       valid, locked;
    logic [3:0] offset;

    int n_chk  = 0;
    int n_pass = 0;
    logic bitq[$];

    localparam logic [6:0] TA = 7'h63;
    localparam logic [6:0] TB = 7'h1C;

    lvds_deserializer dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .realign (realign),
        .word_a  (word_a),
        .word_b  (word_b),
        .valid   (valid),
        .locked  (locked),
        .offset  (offset)
    );

    always #5 clk = ~clk;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task push_frame(input logic [6:0] a, input logic [6:0] b);
        logic [13:0] f;
        f = {b, a};
        for (int i = 0; i < 14; i++) bitq.push_back(f[i]);
    endtask

    task push_zero(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(1'b0);
    endtask

    task pop_bit(output logic b);
        b = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
    endtask

    task step(input logic rl);
        logic b1, b0;
        @(negedge clk);
        pop_bit(b1);
        pop_bit(b0);
        din     = {b1, b0};
        realign = rl;
        @(posedge clk);
        #1;
        realign = 1'b0;
    endtask

    task run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Release lands just after a rising edge so the next edge is phase 0.
    task do_reset();
        rst     = 1'b1;
        realign = 1'b0;
        din     = '0;
        bitq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nv;

        // Aligned training stream: lock on the 4th boundary (edge 28).
        do_reset();
        chk("rst_word_a", word_a, 7'h00);
        chk("rst_word_b", word_b, 7'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_offset", offset, 4'd0);
        repeat (5) push_frame(TA, TB);
        push_frame(7'h55, 7'h2A);
        push_frame(7'h7F, 7'h00);
        run(21);
        chk("al_prelock", locked, 1'b0);
        chk("al_prevalid", valid, 1'b0);
        run(7);
        chk("al_locked", locked, 1'b1);
        chk("al_valid", valid, 1'b1);
        chk("al_offset", offset, 4'd0);
        chk("al_word_a", word_a, 7'h63);
        chk("al_word_b", word_b, 7'h1C);
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            nv += int'(valid);
        end
        chk("al_valid_per7", nv, 1);
        chk("al_valid_edge35", valid, 1'b1);
        run(7);
        chk("d1_valid", valid, 1'b1);
        chk("d1_word_a", word_a, 7'h55);
        chk("d1_word_b", word_b, 7'h2A);
        run(7);
        chk("d2_valid", valid, 1'b1);
        chk("d2_word_a", word_a, 7'h7F);
        chk("d2_word_b", word_b, 7'h00);
        run(1);
        chk("d2_hold_valid", valid, 1'b0);
        chk("d2_hold_word_a", word_a, 7'h7F);
        // realign on a frame boundary (edge 56) beats the LOCKED output update.
        run(5);
        step(1'b1);
        chk("rb_valid", valid, 1'b0);
        chk("rb_locked", locked, 1'b0);
        chk("rb_word_a", word_a, 7'h7F);
        chk("rb_word_b", word_b, 7'h00);

        // Corrupted training frame while in CHECK.
        do_reset();
        push_frame(TA, TB);
        push_frame(TA, 7'h00);
        push_frame(TA, TB);
        run(7);
        chk("cr_locked0", locked, 1'b0);
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            nv += int'(valid);
        end
        chk("cr_offset", offset, 4'd1);
        chk("cr_locked", locked, 1'b0);
        chk("cr_no_valid", nv, 0);

        // Frames end 5 bits before each receiver boundary: offsets 0..4 miss,
        // boundaries 5..8 match, lock at edge 63.
        do_reset();
        push_zero(9);
        repeat (12) push_frame(TA, TB);
        run(56);
        chk("sh_prelock", locked, 1'b0);
        chk("sh_offset_b7", offset, 4'd5);
        run(7);
        chk("sh_locked", locked, 1'b1);
        chk("sh_valid", valid, 1'b1);
        chk("sh_offset", offset, 4'd5);
        chk("sh_word_a", word_a, 7'h63);
        chk("sh_word_b", word_b, 7'h1C);
        // Mid-frame realign at edge 67, relock four boundaries later (edge 91).
        run(3);
        step(1'b1);
        chk("ra_locked", locked, 1'b0);
        chk("ra_valid", valid, 1'b0);
        run(17);
        chk("ra_prelock", locked, 1'b0);
        run(7);
        chk("ra_relocked", locked, 1'b1);
        chk("ra_valid2", valid, 1'b1);
        chk("ra_offset", offset, 4'd5);

        // Asynchronous reset at phase 3 while locked (after edge 94).
        run(3);
        rst = 1'b1;
        #1;
        chk("ar_locked", locked, 1'b0);
        chk("ar_valid", valid, 1'b0);
        chk("ar_offset", offset, 4'd0);
        chk("ar_word_a", word_a, 7'h00);
        chk("ar_word_b", word_b, 7'h00);
        do_reset();
        repeat (5) push_frame(TA, TB);
        run(28);
        chk("ar_relock", locked, 1'b1);
        chk("ar_revalid", valid, 1'b1);
        chk("ar_reoffset", offset, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
